vga_sprite_animator: RTL and testbench
======================================

Name: vga_sprite_animator

Overview:
- Pixel-generation stage directly downstream of the 25 MHz VGA timing generator.
- Consumes hpos/vpos/enable/hs/vs and produces registered 8-bit RGB plus delay-matched syncs.
- Draws a square sprite on a solid background; the sprite bounces around the visible area, moving once per frame during vertical blanking.
- Keeps a frame counter and an edge-bounce counter for status/debug.

Parameters:
- SIZE, 32: sprite edge length in pixels (legal range 1..64).
- SPEED, 2: pixels moved per axis per frame (legal range 1..15).
- X0, 100: sprite x position after reset, screen-relative.
- Y0, 50: sprite y position after reset, screen-relative.
- FG, 8'hE0: sprite colour, RRRGGGBB.
- BG, 8'h03: background colour, RRRGGGBB.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous reset, active-low.
- hs_in  in  1  horizontal sync from timing generator.
- vs_in  in  1  vertical sync from timing generator.
- hpos  in  10  horizontal counter, 0..799.
- vpos  in  10  vertical counter, 0..524.
- enable  in  1  visible-area flag from timing generator.
- run  in  1  1 = animate; 0 = freeze position.
- rgb  out  8  pixel colour RRRGGGBB, registered.
- hs_out  out  1  hs_in delayed 1 cycle.
- vs_out  out  1  vs_in delayed 1 cycle.
- sprite_x  out  10  current screen-relative x.
- sprite_y  out  10  current screen-relative y.
- frame_count  out  16  frames since reset, wraps.
- bounce_count  out  8  edge bounces since reset, saturating.

Behaviour:
- Reset: one clock with reset=0 at a rising edge sets:
  - rgb=0, hs_out=0, vs_out=0.
  - sprite_x=X0, sprite_y=Y0.
  - x direction = +, y direction = +.
  - frame_count=0, bounce_count=0.
- Reset mid-frame takes effect on the next edge; outputs resume from reset values with no partial state.
- Screen-relative coordinates:
  - sx = hpos-145, sy = vpos-36; both are meaningful only while enable=1.
  - Visible width W=639 (hpos 145..783); height H=479 (vpos 36..514).
  - XMAX = W-SIZE; YMAX = H-SIZE.
- Pixel path, latency exactly 1 cycle:
  - rgb <= 0 when enable=0.
  - Otherwise rgb <= FG if sprite_x <= sx < sprite_x+SIZE and sprite_y <= sy < sprite_y+SIZE.
  - Otherwise rgb <= BG.
  - hs_out <= hs_in; vs_out <= vs_in. rgb and syncs always stay aligned.
  - All comparisons use at least 11 bits; no wrap artefacts.
- Frame tick:
  - Single-cycle internal pulse when vpos==515 && hpos==0, i.e. first cycle of vertical blanking.
  - Exactly one tick per 525-line frame.
  - Position therefore never changes while visible pixels are drawn.
- On each tick:
  - frame_count increments, wrapping 65535->0, regardless of run.
  - If run=1, each axis updates independently. For the x axis (y is identical, with YMAX):
    - Direction +: if x+SPEED >= XMAX, then x <= XMAX, direction <= -, bounce event. Else x <= x+SPEED.
    - Direction -: if x <= SPEED, then x <= 0, direction <= +, bounce event. Else x <= x-SPEED.
    - Bounce events from both axes on the same tick (corner) increment bounce_count by 1, not 2.
    - bounce_count saturates at 255.
  - If run=0: position, directions and bounce_count hold.
  - run is sampled only on the tick cycle; changes at other times have no effect until the next tick.
- Invariant: 0 <= sprite_x <= XMAX and 0 <= sprite_y <= YMAX at all times after reset.
- Direction state per axis is a 2-state FSM (INC, DEC). Transitions occur only on a bounce event.

Test Plan:
- Reset held 3 cycles then released, with hpos=200, vpos=100, enable=1 -> next cycle rgb=BG; sprite_x=100, sprite_y=50; frame_count=0.
- Full frame, run=1, defaults -> pixel (hpos=245, vpos=86) gives rgb=8'hE0 one cycle later; (hpos=277, vpos=86) gives 8'h03; hpos=100 gives 8'h00; hs_out equals hs_in delayed 1 cycle.
- One tick with run=1 -> sprite_x=102, sprite_y=52, frame_count=1. After 10 frames -> 120, 70, frame_count=10.
- Reset defaults, force-run until x reaches the right edge (XMAX=607): the tick that would exceed clamps to 607, bounce_count=1, and the next tick gives 605.
- Corner test with X0=605, Y0=445 -> first tick gives x=607, y=447, bounce_count=1 (not 2), both directions now -.
- run=0 across 5 frames -> position unchanged, frame_count +5. Toggle run high mid-frame -> motion resumes only at the next vpos=515, hpos=0 tick. Assert reset mid-frame -> state returns to X0/Y0 on the next edge.

Source files
------------

// File: rtl/vga_sprite_animator.sv
// Pixel stage after the VGA timing generator: draws a bouncing square sprite on a
// solid background, with a 1-cycle registered pixel path and delay-matched syncs.
module vga_sprite_animator #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned SPEED = 2,
  parameter int unsigned X0    = 100,
  parameter int unsigned Y0    = 50,
  parameter logic [7:0]  FG    = 8'hE0,
  parameter logic [7:0]  BG    = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        enable,
  input  logic        run,
  output logic [7:0]  rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic [15:0] frame_count,
  output logic [7:0]  bounce_count
);

  localparam int unsigned CW     = 11;
  localparam int unsigned HSTART = 145;
  localparam int unsigned VSTART = 36;
  localparam int unsigned XMAX   = 639 - SIZE;
  localparam int unsigned YMAX   = 479 - SIZE;

  localparam logic [0:0] INC = 1'b0;
  localparam logic [0:0] DEC = 1'b1;

  logic [0:0]    x_dir, y_dir, x_dir_nx, y_dir_nx;
  logic [CW-1:0] x_ext, y_ext, x_nx, y_nx;
  logic [CW-1:0] sx, sy;
  logic          x_bnc, y_bnc;
  logic          tick, in_sprite;

  assign x_ext = {1'b0, sprite_x};
  assign y_ext = {1'b0, sprite_y};
  assign sx    = {1'b0, hpos} - CW'(HSTART);
  assign sy    = {1'b0, vpos} - CW'(VSTART);

  // First cycle of vertical blanking: position never moves while pixels are drawn
  assign tick = (vpos == 10'd515) && (hpos == 10'd0);

  assign in_sprite = (sx >= x_ext) && (sx < x_ext + CW'(SIZE)) &&
                     (sy >= y_ext) && (sy < y_ext + CW'(SIZE));

  // Per-axis next position / direction, evaluated only on a running tick
  always_comb begin
    x_nx     = x_ext;
    y_nx     = y_ext;
    x_dir_nx = x_dir;
    y_dir_nx = y_dir;
    x_bnc    = 1'b0;
    y_bnc    = 1'b0;
    if (tick && run) begin
      case (x_dir)
        INC: begin
          if (x_ext + CW'(SPEED) >= CW'(XMAX)) begin
            x_nx = CW'(XMAX); x_dir_nx = DEC; x_bnc = 1'b1;
          end else begin
            x_nx = x_ext + CW'(SPEED);
          end
        end
        default: begin
          if (x_ext <= CW'(SPEED)) begin
            x_nx = '0; x_dir_nx = INC; x_bnc = 1'b1;
          end else begin
            x_nx = x_ext - CW'(SPEED);
          end
        end
      endcase
      case (y_dir)
        INC: begin
          if (y_ext + CW'(SPEED) >= CW'(YMAX)) begin
            y_nx = CW'(YMAX); y_dir_nx = DEC; y_bnc = 1'b1;
          end else begin
            y_nx = y_ext + CW'(SPEED);
          end
        end
        default: begin
          if (y_ext <= CW'(SPEED)) begin
            y_nx = '0; y_dir_nx = INC; y_bnc = 1'b1;
          end else begin
            y_nx = y_ext - CW'(SPEED);
          end
        end
      endcase
    end
  end

  // Direction FSMs and position registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_dir    <= INC;
      y_dir    <= INC;
      sprite_x <= 10'(X0);
      sprite_y <= 10'(Y0);
    end else begin
      x_dir    <= x_dir_nx;
      y_dir    <= y_dir_nx;
      sprite_x <= x_nx[9:0];
      sprite_y <= y_nx[9:0];
    end
  end

  // Frame and bounce counters; a corner hit counts as one bounce
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_count  <= '0;
      bounce_count <= '0;
    end else begin
      if (tick) frame_count <= frame_count + 16'd1;
      if ((x_bnc || y_bnc) && (bounce_count != 8'hFF))
        bounce_count <= bounce_count + 8'd1;
    end
  end

  // Pixel path and sync delay, kept on the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb    <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      hs_out <= hs_in;
      vs_out <= vs_in;
      if (!enable)        rgb <= 8'h00;
      else if (in_sprite) rgb <= FG;
      else                rgb <= BG;
    end
  end

endmodule

// File: tb/tb_vga_sprite_animator.sv
// Directed bench for vga_sprite_animator: pixel vectors from a table plus
// hand-written tick sequences for motion, bounce, corner, run gating and reset.
module tb_vga_sprite_animator;

  logic        clk = 1'b0;
  logic        reset, hs_in, vs_in, enable, run;
  logic [9:0]  hpos, vpos;
  logic [7:0]  rgb, rgb_c, bc, bc_c;
  logic        hs_out, vs_out, hs_c, vs_c;
  logic [9:0]  sx, sy, sx_c, sy_c;
  logic [15:0] fc, fc_c;

  int nvec = 0;
  int nfail = 0;

  always #20 clk = ~clk;

  vga_sprite_animator dut (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .hpos(hpos), .vpos(vpos),
    .enable(enable), .run(run), .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out),
    .sprite_x(sx), .sprite_y(sy), .frame_count(fc), .bounce_count(bc)
  );

  vga_sprite_animator #(.X0(605), .Y0(445)) dut_c (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .hpos(hpos), .vpos(vpos),
    .enable(enable), .run(run), .rgb(rgb_c), .hs_out(hs_c), .vs_out(vs_c),
    .sprite_x(sx_c), .sprite_y(sy_c), .frame_count(fc_c), .bounce_count(bc_c)
  );

  typedef struct {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       en;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hpos = 10'd10; vpos = 10'd520; enable = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
  endtask

  task automatic do_tick();
    hpos = 10'd0; vpos = 10'd515; enable = 1'b0;
    cyc();
    idle_inputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    vec[0] = '{10'd245, 10'd86,  1'b1, 1'b1, 1'b0, 8'hE0};
    vec[1] = '{10'd277, 10'd86,  1'b1, 1'b0, 1'b1, 8'h03};
    vec[2] = '{10'd276, 10'd86,  1'b1, 1'b1, 1'b1, 8'hE0};
    vec[3] = '{10'd244, 10'd86,  1'b1, 1'b0, 1'b0, 8'h03};
    vec[4] = '{10'd245, 10'd85,  1'b1, 1'b1, 1'b0, 8'h03};
    vec[5] = '{10'd245, 10'd117, 1'b1, 1'b0, 1'b1, 8'hE0};
    vec[6] = '{10'd245, 10'd118, 1'b1, 1'b1, 1'b0, 8'h03};
    vec[7] = '{10'd100, 10'd86,  1'b0, 1'b0, 1'b0, 8'h00};
    vec[8] = '{10'd245, 10'd86,  1'b0, 1'b1, 1'b1, 8'h00};
    vec[9] = '{10'd145, 10'd36,  1'b1, 1'b0, 1'b1, 8'h03};

    // Reset held 3 cycles with a visible pixel on the inputs
    run = 1'b1; reset = 1'b0;
    hpos = 10'd200; vpos = 10'd100; enable = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hs", int'(hs_out), 0);
    chk("reset_vs", int'(vs_out), 0);
    reset = 1'b1;
    cyc();
    chk("post_reset_rgb", int'(rgb), 8'h03);
    chk("post_reset_x", int'(sx), 100);
    chk("post_reset_y", int'(sy), 50);
    chk("post_reset_fc", int'(fc), 0);
    chk("post_reset_bc", int'(bc), 0);

    // Pixel / sync vectors, sprite at (100,50)
    for (int i = 0; i < 10; i++) begin
      hpos = vec[i].hpos; vpos = vec[i].vpos; enable = vec[i].en;
      hs_in = vec[i].hs; vs_in = vec[i].vs;
      cyc();
      chk($sformatf("vec%0d_rgb", i), int'(rgb), int'(vec[i].rgb));
      chk($sformatf("vec%0d_hs", i), int'(hs_out), int'(vec[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vs_out), int'(vec[i].vs));
    end
    idle_inputs();

    // First tick: normal step on dut, corner bounce on dut_c
    do_tick();
    chk("tick1_x", int'(sx), 102);
    chk("tick1_y", int'(sy), 52);
    chk("tick1_fc", int'(fc), 1);
    chk("corner_x", int'(sx_c), 607);
    chk("corner_y", int'(sy_c), 447);
    chk("corner_bc", int'(bc_c), 1);
    do_tick();
    chk("corner_dec_x", int'(sx_c), 605);
    chk("corner_dec_y", int'(sy_c), 445);
    chk("corner_dec_bc", int'(bc_c), 1);
    ticks(8);
    chk("tick10_x", int'(sx), 120);
    chk("tick10_y", int'(sy), 70);
    chk("tick10_fc", int'(fc), 10);

    // Frozen for 5 frames
    run = 1'b0;
    ticks(5);
    chk("frozen_x", int'(sx), 120);
    chk("frozen_y", int'(sy), 70);
    chk("frozen_fc", int'(fc), 15);

    // run raised mid-frame: no motion until the next tick
    for (int i = 0; i < 3; i++) cyc();
    run = 1'b1;
    hpos = 10'd300; vpos = 10'd200; enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("midframe_run_x", int'(sx), 120);
    chk("midframe_run_y", int'(sy), 70);
    idle_inputs();
    do_tick();
    chk("resume_x", int'(sx), 122);
    chk("resume_y", int'(sy), 72);
    chk("resume_fc", int'(fc), 16);

    // run low only at the tick cycle blocks motion
    run = 1'b0;
    do_tick();
    run = 1'b1;
    cyc();
    chk("run_low_tick_x", int'(sx), 122);
    chk("run_low_tick_fc", int'(fc), 17);

    // Reset mid-frame
    hpos = 10'd400; vpos = 10'd300; enable = 1'b1;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("midreset_x", int'(sx), 100);
    chk("midreset_y", int'(sy), 50);
    chk("midreset_fc", int'(fc), 0);
    chk("midreset_rgb", int'(rgb), 0);
    idle_inputs();

    // Run from reset: y hits bottom at tick 199, x hits right edge at tick 254
    ticks(199);
    chk("ybounce_y", int'(sy), 447);
    chk("ybounce_x", int'(sx), 498);
    chk("ybounce_bc", int'(bc), 1);
    ticks(55);
    chk("xbounce_x", int'(sx), 607);
    chk("xbounce_y", int'(sy), 337);
    chk("xbounce_bc", int'(bc), 2);
    do_tick();
    chk("after_xbounce_x", int'(sx), 605);
    chk("after_xbounce_y", int'(sy), 335);
    chk("after_fc", int'(fc), 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
